erode_window_ctrl: RTL and testbench

- Front-end controller and line buffer for the 3x3 erosion min-filter datapath.
- Accepts a raster pixel stream, stores the two previous rows, and emits vertically aligned 3-pixel columns (top/mid/bot) with a qualifying valid that drive the filter's din1/din2/din3/valid_in inputs.
- Sequences each frame through fill, run and flush phases, and pads the top and bottom image borders.
- Marks row start and row end so the downstream horizontal window can handle the left and right edges.

---
 rtl/erode_window_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_erode_window_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erode_window_ctrl.sv
// erode_window_ctrl: front-end controller and two-row line buffer for the
// 3x3 erosion min filter. It takes a raster pixel stream and emits aligned
// top/mid/bot columns. The top and bottom image borders are padded. Each
// frame runs through the FILL, RUN and FLUSH phases.
// Optional build macro: ERODE_PAD_REPLICATE_EN. When it is defined, the
// border rows copy the nearest image row instead of using PAD_VAL.
//
// Handshake: a pixel transfers on a rising edge where pix_valid & pix_ready.
// pix_ready depends only on the state (FILL or RUN). The output side has no
// backpressure: each win_valid cycle carries one column, and the consumer
// must take it in that cycle.
module erode_window_ctrl #(
    parameter int               WIDTH      = 24,
    parameter int               PIC_WIDTH  = 640,
    parameter int               PIC_HEIGHT = 480,
    parameter logic [WIDTH-1:0] PAD_VAL    = {WIDTH{1'b1}},
    localparam int              CW         = $clog2(PIC_WIDTH),
    localparam int              RW         = $clog2(PIC_HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] pix_data,
    output logic             pix_ready,
    output logic             win_valid,
    output logic [WIDTH-1:0] win_top,
    output logic [WIDTH-1:0] win_mid,
    output logic [WIDTH-1:0] win_bot,
    output logic [CW-1:0]    win_col,
    output logic [RW-1:0]    win_row,
    output logic             win_sol,
    output logic             win_eol,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic             win_valid_q;
    logic [WIDTH-1:0] win_top_q;
    logic [WIDTH-1:0] win_mid_q;
    logic [WIDTH-1:0] win_bot_q;
    logic [CW-1:0]    win_col_q;
    logic [RW-1:0]    win_row_q;
    logic             win_sol_q;
    logic             win_eol_q;
    logic             done_pend_q;
    logic             frame_done_q;

    // lb0 holds the previous row and lb1 holds the row before that.
    logic [WIDTH-1:0] lb0_q [PIC_WIDTH];
    logic [WIDTH-1:0] lb1_q [PIC_WIDTH];

    logic             xfer;
    logic             last_col;
    logic             last_row;
    logic             lb_wr;
    logic [WIDTH-1:0] lb0_rd;
    logic [WIDTH-1:0] lb1_rd;
    logic [WIDTH-1:0] top_row1;
    logic [WIDTH-1:0] bot_flush;

    assign pix_ready = (state_q == S_FILL) || (state_q == S_RUN);
    assign xfer      = pix_valid && pix_ready;
    assign last_col  = (col_q == CW'(PIC_WIDTH - 1));
    assign last_row  = (row_q == RW'(PIC_HEIGHT - 1));
    assign lb0_rd    = lb0_q[col_q];
    assign lb1_rd    = lb1_q[col_q];
    // A pixel that arrives in the same cycle as a restart is dropped.
    assign lb_wr     = rst_n && xfer && !frame_start;

`ifdef ERODE_PAD_REPLICATE_EN
    assign top_row1  = lb0_rd;
    assign bot_flush = lb0_rd;
`else
    assign top_row1  = PAD_VAL;
    assign bot_flush = PAD_VAL;
`endif

    // Line buffer: the reads above see the old contents, so each row shifts down one slot on a write.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lb0_q[col_q] <= pix_data;
            if (state_q == S_RUN) begin
                lb1_q[col_q] <= lb0_q[col_q];
            end
        end
    end

    // Frame sequencer: state, col/row counters and all registered window outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_top_q    <= '0;
            win_mid_q    <= '0;
            win_bot_q    <= '0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            win_sol_q    <= 1'b0;
            win_eol_q    <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= 1'b0;
            win_sol_q    <= 1'b0;
            win_eol_q    <= 1'b0;
            done_pend_q  <= 1'b0;
            frame_done_q <= done_pend_q;
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q <= S_FILL;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                S_FILL: begin
                    if (frame_start) begin
                        col_q <= '0;
                        row_q <= '0;
                    end else if (xfer) begin
                        if (last_col) begin
                            col_q   <= '0;
                            row_q   <= RW'(1);
                            state_q <= S_RUN;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_RUN: begin
                    if (frame_start) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= S_FILL;
                    end else if (xfer) begin
                        win_valid_q <= 1'b1;
                        win_top_q   <= (row_q == RW'(1)) ? top_row1 : lb1_rd;
                        win_mid_q   <= lb0_rd;
                        win_bot_q   <= pix_data;
                        win_row_q   <= row_q - RW'(1);
                        win_col_q   <= col_q;
                        win_sol_q   <= (col_q == '0);
                        win_eol_q   <= last_col;
                        if (last_col) begin
                            col_q <= '0;
                            if (last_row) begin
                                state_q <= S_FLUSH;
                            end else begin
                                row_q <= row_q + RW'(1);
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (frame_start && !last_col) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= S_FILL;
                    end else begin
                        // The bottom image row becomes the center row, and padding fills the row below it.
                        win_valid_q <= 1'b1;
                        win_top_q   <= lb1_rd;
                        win_mid_q   <= lb0_rd;
                        win_bot_q   <= bot_flush;
                        win_row_q   <= RW'(PIC_HEIGHT - 1);
                        win_col_q   <= col_q;
                        win_sol_q   <= (col_q == '0);
                        win_eol_q   <= last_col;
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= '0;
                            if (frame_start) begin
                                state_q <= S_FILL;
                            end else begin
                                state_q     <= S_IDLE;
                                done_pend_q <= 1'b1;
                            end
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign win_valid  = win_valid_q;
    assign win_top    = win_top_q;
    assign win_mid    = win_mid_q;
    assign win_bot    = win_bot_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign win_sol    = win_sol_q;
    assign win_eol    = win_eol_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_erode_window_ctrl.sv
// Directed bench for erode_window_ctrl with a 4x3 image of 8-bit pixels.
// Each pixel value is 16*row+col.
module tb_erode_window_ctrl;

  localparam int PW = 4;
  localparam int PH = 3;
  localparam logic [7:0] PAD = 8'hFF;
  localparam int CAPW = 30;

  logic       clk;
  logic       rst_n;
  logic       frame_start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic       win_valid;
  logic [7:0] win_top;
  logic [7:0] win_mid;
  logic [7:0] win_bot;
  logic [1:0] win_col;
  logic [1:0] win_row;
  logic       win_sol;
  logic       win_eol;
  logic       busy;
  logic       frame_done;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CAPW-1:0] cap_q[$];
  logic [CAPW-1:0] exp_q[$];
  int cyc = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int flush_cnt = 0;

  erode_window_ctrl #(
    .WIDTH(8), .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .PAD_VAL(PAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .win_valid(win_valid), .win_top(win_top), .win_mid(win_mid),
    .win_bot(win_bot), .win_col(win_col), .win_row(win_row),
    .win_sol(win_sol), .win_eol(win_eol), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output monitor, samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (win_valid) begin
      cap_q.push_back({win_row, win_col, win_sol, win_eol, win_top, win_mid, win_bot});
      last_valid_cyc = cyc;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !pix_ready) flush_cnt++;
  end

  function automatic logic [CAPW-1:0] mk_exp(int r, int c);
    logic [7:0] t, m, b;
    m = 8'(16 * r + c);
    t = (r == 0) ? PAD : 8'(16 * (r - 1) + c);
    b = (r == PH - 1) ? PAD : 8'(16 * (r + 1) + c);
`ifdef ERODE_PAD_REPLICATE_EN
    if (r == 0) t = m;
    if (r == PH - 1) b = m;
`endif
    return {2'(r), 2'(c), (c == 0), (c == PW - 1), t, m, b};
  endfunction

  function automatic void load_exp();
    exp_q.delete();
    for (int i = 0; i < PW * PH; i++) exp_q.push_back(mk_exp(i / PW, i % PW));
  endfunction

  // driver tasks
  task automatic clr_mon();
    cap_q.delete();
    done_cnt = 0;
    flush_cnt = 0;
  endtask

  task automatic start_frame(input logic with_pix);
    @(negedge clk);
    frame_start = 1'b1;
    pix_valid = with_pix;
    pix_data = 8'h55;
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input logic gapped);
    for (int i = first; i <= last; i++) begin
      pix_valid = 1'b1;
      pix_data = 8'(16 * (i / PW) + (i % PW));
      @(negedge clk);
      if (gapped) begin
        pix_valid = 1'b0;
        pix_data = 8'hAA;
        @(negedge clk);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && done_cnt == 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_flush();
    for (int k = 0; k < 60 && dbg_state != 2'd3; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    n_tests++;
    if ({pix_ready, win_valid, busy, frame_done, win_sol, win_eol} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {pix_ready, win_valid, busy, frame_done, win_sol, win_eol});
    end
    n_tests++;
    if ({win_top, win_mid, win_bot, win_col, win_row} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_data got=%h want=0", {win_top, win_mid, win_bot, win_col, win_row});
    end
    n_tests++;
    if (dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d want=0", dbg_state);
    end
  endtask

  task automatic test_full_frame(input logic gapped);
    logic [CAPW-1:0] e, o;
    clr_mon();
    start_frame(1'b0);
    send_range(0, PW * PH - 1, gapped);
    wait_done();
    load_exp();
    n_tests++;
    if (cap_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL frame_cols gapped=%0d got=%0d want=%0d", gapped, cap_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      o = cap_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL frame_col gapped=%0d got=%h want=%h", gapped, o, e);
      end
    end
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame_done_cnt got=%0d want=1", done_cnt);
    end
    n_tests++;
    if (done_cyc !== last_valid_cyc + 1) begin
      n_fail++;
      $display("FAIL frame_done_timing got=%0d want=%0d", done_cyc, last_valid_cyc + 1);
    end
    n_tests++;
    if (flush_cnt !== PW) begin
      n_fail++;
      $display("FAIL flush_ready_low got=%0d want=%0d", flush_cnt, PW);
    end
  endtask

  task automatic test_latency();
    clr_mon();
    start_frame(1'b0);
    send_range(0, PW, 1'b0);
    pix_valid = 1'b1;
    pix_data = 8'h11;
    @(posedge clk);
    #1;
    n_tests++;
    if (win_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_valid got=%b want=1", win_valid);
    end
    n_tests++;
    if ({win_top, win_mid, win_bot, win_row, win_col} !== {8'hFF, 8'h01, 8'h11, 2'd0, 2'd1}) begin
      n_fail++;
      $display("FAIL latency_col got=%h want=%h", {win_top, win_mid, win_bot, win_row, win_col},
               {8'hFF, 8'h01, 8'h11, 2'd0, 2'd1});
    end
    @(negedge clk);
    send_range(PW + 2, PW * PH - 1, 1'b0);
    wait_done();
    n_tests++;
    if (cap_q.size() !== PW * PH || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL latency_frame cols=%0d done=%0d want cols=%0d done=1", cap_q.size(), done_cnt, PW * PH);
    end
  endtask

  task automatic test_abort();
    logic [CAPW-1:0] e, o;
    clr_mon();
    start_frame(1'b0);
    send_range(0, 5, 1'b0);
    start_frame(1'b1);
    n_tests++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_state got=%0d want=1", dbg_state);
    end
    clr_mon();
    send_range(0, PW * PH - 1, 1'b0);
    wait_done();
    load_exp();
    n_tests++;
    if (cap_q.size() !== exp_q.size() || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_frame cols=%0d done=%0d want cols=%0d done=1", cap_q.size(), done_cnt, exp_q.size());
    end
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      o = cap_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_col got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [CAPW-1:0] o;
    clr_mon();
    start_frame(1'b0);
    send_range(0, PW * PH - 1, 1'b0);
    wait_flush();
    repeat (PW - 1) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cap_q.size() !== PW * PH) begin
      n_fail++;
      $display("FAIL b2b_cols got=%0d want=%0d", cap_q.size(), PW * PH);
    end
    if (cap_q.size() > 0) begin
      o = cap_q[cap_q.size() - 1];
      n_tests++;
      if (o !== mk_exp(PH - 1, PW - 1)) begin
        n_fail++;
        $display("FAIL b2b_last_col got=%h want=%h", o, mk_exp(PH - 1, PW - 1));
      end
    end
    n_tests++;
    if (done_cnt !== 0 || dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL b2b_restart done=%0d state=%0d want done=0 state=1", done_cnt, dbg_state);
    end
    clr_mon();
    send_range(0, PW * PH - 1, 1'b0);
    wait_done();
    n_tests++;
    if (cap_q.size() !== PW * PH || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL b2b_second cols=%0d done=%0d want cols=%0d done=1", cap_q.size(), done_cnt, PW * PH);
    end
  endtask

  task automatic test_reset_in_flush();
    start_frame(1'b0);
    send_range(0, PW * PH - 1, 1'b0);
    wait_flush();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if ({pix_ready, win_valid, busy, frame_done, win_sol, win_eol, dbg_state} !== 8'b0) begin
      n_fail++;
      $display("FAIL flush_reset_ctrl got=%b want=0",
               {pix_ready, win_valid, busy, frame_done, win_sol, win_eol, dbg_state});
    end
    n_tests++;
    if ({win_top, win_mid, win_bot, win_col, win_row} !== 28'h0) begin
      n_fail++;
      $display("FAIL flush_reset_data got=%h want=0", {win_top, win_mid, win_bot, win_col, win_row});
    end
    clr_mon();
    pix_valid = 1'b1;
    pix_data = 8'h42;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (pix_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ready cyc=%0d got=%b want=0", k, pix_ready);
      end
    end
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cap_q.size() !== 0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet cols=%0d done=%0d want 0 0", cap_q.size(), done_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_frame(1'b0);
    test_full_frame(1'b1);
    test_latency();
    test_abort();
    test_back_to_back();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
